// File: rtl/ws2812_pixel_decoder.sv
// WS2812 receive front end: measures high pulses on a synchronised data line,
// assembles pixel words and hands them downstream over valid/ready.
module ws2812_pixel_decoder #(
   parameter int CNT_WIDTH      = 13,
   parameter int BITS_PER_PIXEL = 24,
   parameter int T0H_MIN        = 25,
   parameter int T0H_MAX        = 55,
   parameter int T1H_MIN        = 65,
   parameter int T1H_MAX        = 100,
   parameter int TRESET_CYCLES  = 5000,
   parameter int MSB_FIRST      = 1,
   parameter int IDX_WIDTH      = 10
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_din,
   output logic [BITS_PER_PIXEL-1:0] o_pixel_data,
   output logic [IDX_WIDTH-1:0]      o_pixel_index,
   output logic                      o_pixel_valid,
   input  logic                      i_pixel_ready,
   output logic                      o_frame_end,
   output logic                      o_bit_error,
   output logic                      o_overrun,
   output logic                      o_busy
);

   localparam int BCW = (BITS_PER_PIXEL > 2) ? $clog2(BITS_PER_PIXEL) : 1;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [CNT_WIDTH-1:0] T0_MIN     = CNT_WIDTH'(T0H_MIN);
   localparam logic [CNT_WIDTH-1:0] T0_MAX     = CNT_WIDTH'(T0H_MAX);
   localparam logic [CNT_WIDTH-1:0] T1_MIN     = CNT_WIDTH'(T1H_MIN);
   localparam logic [CNT_WIDTH-1:0] T1_MAX     = CNT_WIDTH'(T1H_MAX);
   localparam logic [CNT_WIDTH-1:0] TRESET_CNT = CNT_WIDTH'(TRESET_CYCLES);
   localparam logic [BCW-1:0]       LAST_BIT   = BCW'(BITS_PER_PIXEL - 1);

   typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

   state_t                    state_q;
   logic                      din_q;
   logic [CNT_WIDTH-1:0]      cnt_q;
   logic [BCW-1:0]            bit_cnt_q;
   logic [BITS_PER_PIXEL-1:0] shift_q;
   logic [IDX_WIDTH-1:0]      idx_q;

   logic                      rise;
   logic                      fall;
   logic                      low_timeout;
   logic                      is_one;
   logic                      is_zero;
   logic [BITS_PER_PIXEL-1:0] shift_next;

   assign rise = i_din & ~din_q;
   assign fall = ~i_din & din_q;
   // Low on both samples so a long high pulse's count cannot be mistaken for treset.
   assign low_timeout = ~i_din & ~din_q & (cnt_q >= TRESET_CNT);
   assign is_one  = (cnt_q >= T1_MIN) && (cnt_q <= T1_MAX);
   assign is_zero = (cnt_q >= T0_MIN) && (cnt_q <= T0_MAX);

   // NOTE: always_comb assigns a default first so no path leaves shift_next unassigned (no latch).
   always_comb begin
      shift_next = shift_q;
      if (MSB_FIRST != 0) shift_next = {shift_q[BITS_PER_PIXEL-2:0], is_one};
      else                shift_next = {is_one, shift_q[BITS_PER_PIXEL-1:1]};
   end

   // NOTE: all state updates are non-blocking so every register sees pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= S_SYNC;
         din_q         <= 1'b0;
         cnt_q         <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         idx_q         <= '0;
         o_pixel_data  <= '0;
         o_pixel_index <= '0;
         o_pixel_valid <= 1'b0;
         o_frame_end   <= 1'b0;
         o_bit_error   <= 1'b0;
         o_overrun     <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         din_q       <= i_din;
         o_frame_end <= 1'b0;
         o_bit_error <= 1'b0;
         o_overrun   <= 1'b0;

         if (rise || fall)        cnt_q <= CNT_WIDTH'(1);
         else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;

         if (o_pixel_valid && i_pixel_ready) o_pixel_valid <= 1'b0;

         case (state_q)
            S_SYNC: begin
               if (low_timeout) state_q <= S_IDLE;
            end
            S_IDLE: begin
               if (rise) begin
                  state_q <= S_HIGH;
                  o_busy  <= 1'b1;
               end
            end
            S_HIGH: begin
               if (fall) begin
                  if (is_one || is_zero) begin
                     state_q <= S_LOW;
                     if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                        idx_q     <= idx_q + 1'b1;
                        // A word still waiting downstream wins; the new one is dropped.
                        if (o_pixel_valid && !i_pixel_ready) begin
                           o_overrun <= 1'b1;
                        end else begin
                           o_pixel_data  <= shift_next;
                           o_pixel_index <= idx_q;
                           o_pixel_valid <= 1'b1;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        shift_q   <= shift_next;
                     end
                  end else begin
                     o_bit_error <= 1'b1;
                     bit_cnt_q   <= '0;
                     shift_q     <= '0;
                     state_q     <= S_SYNC;
                     o_busy      <= 1'b0;
                  end
               end
            end
            S_LOW: begin
               if (rise) begin
                  state_q <= S_HIGH;
               end else if (low_timeout) begin
                  o_frame_end <= 1'b1;
                  idx_q       <= '0;
                  bit_cnt_q   <= '0;
                  shift_q     <= '0;
                  state_q     <= S_IDLE;
                  o_busy      <= 1'b0;
               end
            end
            default: begin
               state_q <= S_SYNC;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_pixel_decoder.sv
// Directed bench for ws2812_pixel_decoder: an RGB MSB-first instance and an
// RGBW LSB-first instance driven from hand-built pulse trains.
module tb_ws2812_pixel_decoder;

   localparam int IDLE = 5005;

   typedef struct packed {
      logic [9:0]  idx;
      logic [31:0] data;
   } px_t;

   typedef struct {
      logic [23:0] word;
      logic        gap_after;
      logic [23:0] exp_data;
      logic [9:0]  exp_idx;
   } vec_t;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic din0 = 1'b0;
   logic din1 = 1'b0;
   logic rdy0 = 1'b1;
   logic rdy1 = 1'b1;

   logic [23:0] d0_data;
   logic [9:0]  d0_index;
   logic        d0_valid, d0_fe, d0_err, d0_ov, d0_busy;
   logic [31:0] d1_data;
   logic [9:0]  d1_index;
   logic        d1_valid, d1_fe, d1_err, d1_ov, d1_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ws2812_pixel_decoder dut0 (
      .i_clk(clk), .i_reset(rst), .i_din(din0),
      .o_pixel_data(d0_data), .o_pixel_index(d0_index), .o_pixel_valid(d0_valid),
      .i_pixel_ready(rdy0), .o_frame_end(d0_fe), .o_bit_error(d0_err),
      .o_overrun(d0_ov), .o_busy(d0_busy)
   );

   ws2812_pixel_decoder #(.BITS_PER_PIXEL(32), .MSB_FIRST(0)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_din(din1),
      .o_pixel_data(d1_data), .o_pixel_index(d1_index), .o_pixel_valid(d1_valid),
      .i_pixel_ready(rdy1), .o_frame_end(d1_fe), .o_bit_error(d1_err),
      .o_overrun(d1_ov), .o_busy(d1_busy)
   );

   // Event monitor: sole writer of the capture queues and pulse counters.
   px_t         got0[$];
   px_t         got1[$];
   int          fe0 = 0, err0 = 0, ov0 = 0, vcyc0 = 0, hold_bad = 0, fe1 = 0, err1 = 0;
   logic        prev_hold = 1'b0;
   logic [23:0] prev_data = '0;
   logic [9:0]  prev_idx  = '0;

   always @(negedge clk) begin
      if (d0_valid && rdy0) got0.push_back(px_t'({d0_index, 8'h00, d0_data}));
      if (d1_valid && rdy1) got1.push_back(px_t'({d1_index, d1_data}));
      if (d0_valid) vcyc0 <= vcyc0 + 1;
      if (d0_fe)    fe0   <= fe0 + 1;
      if (d0_err)   err0  <= err0 + 1;
      if (d0_ov)    ov0   <= ov0 + 1;
      if (d1_fe)    fe1   <= fe1 + 1;
      if (d1_err)   err1  <= err1 + 1;
      if (!rst && prev_hold && (!d0_valid || d0_data != prev_data || d0_index != prev_idx))
         hold_bad <= hold_bad + 1;
      prev_hold <= d0_valid && !rdy0 && !rst;
      prev_data <= d0_data;
      prev_idx  <= d0_index;
   end

   function automatic px_t get0(input int i);
      px_t r = '1;
      if (i < got0.size()) r = got0[i];
      return r;
   endfunction

   function automatic px_t get1(input int i);
      px_t r = '1;
      if (i < got1.size()) r = got1[i];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Inputs change one time unit after the rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int line, input logic v);
      if (line == 0) din0 = v;
      else           din1 = v;
   endtask

   task automatic send_bit(input int line, input logic b);
      drive(line, 1'b1);
      tick(b ? 80 : 40);
      drive(line, 1'b0);
      tick(b ? 45 : 85);
   endtask

   task automatic send_word(input int line, input logic [31:0] w, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) send_bit(line, w[i]);
   endtask

   vec_t vecs[4];

   initial begin
      int  b_got, b_fe, b_err, b_ov, b_v;
      int  c_got, c_fe, c_err;
      px_t px0, px1;

      vecs[0] = '{24'h123456, 1'b0, 24'h123456, 10'd0};
      vecs[1] = '{24'hFFFFFF, 1'b0, 24'hFFFFFF, 10'd1};
      vecs[2] = '{24'h000000, 1'b1, 24'h000000, 10'd2};
      vecs[3] = '{24'h5A5A5A, 1'b1, 24'h5A5A5A, 10'd0};

      tick(3);
      check("reset_outputs_rgb",
            {d0_valid, d0_fe, d0_err, d0_ov, d0_busy, d0_index, d0_data}, '0);
      check("reset_outputs_rgbw",
            {d1_valid, d1_fe, d1_err, d1_ov, d1_busy, d1_index, d1_data}, '0);
      rst = 1'b0;
      tick(IDLE);

      fork
         begin
            // Single pixel, ready held high.
            b_got = got0.size(); b_v = vcyc0; b_err = err0; b_ov = ov0; b_fe = fe0;
            send_word(0, 32'h00A5C3F0, 24);
            check("t1_busy_in_frame", d0_busy, 1'b1);
            tick(5);
            px0 = get0(b_got);
            check("t1_count", got0.size() - b_got, 1);
            check("t1_data", px0.data, 32'h00A5C3F0);
            check("t1_index", px0.idx, 10'd0);
            check("t1_valid_cycles", vcyc0 - b_v, 1);
            check("t1_no_errors", (err0 - b_err) + (ov0 - b_ov), 0);
            tick(IDLE);
            check("t1_frame_end", fe0 - b_fe, 1);
            check("t1_busy_idle", d0_busy, 1'b0);

            // Back-to-back pixels across two frames.
            b_got = got0.size(); b_fe = fe0;
            foreach (vecs[i]) begin
               send_word(0, {8'h00, vecs[i].word}, 24);
               if (vecs[i].gap_after) tick(IDLE);
            end
            check("t2_count", got0.size() - b_got, 4);
            foreach (vecs[i]) begin
               px0 = get0(b_got + i);
               check($sformatf("t2_data%0d", i), px0.data, {8'h00, vecs[i].exp_data});
               check($sformatf("t2_index%0d", i), px0.idx, vecs[i].exp_idx);
            end
            check("t2_frame_ends", fe0 - b_fe, 2);
         end
         begin
            // LSB-first RGBW instance.
            c_got = got1.size(); c_fe = fe1; c_err = err1;
            send_word(1, 32'h00000001, 32);
            tick(3);
            px1 = get1(c_got);
            check("t5_lsb_first_data", px1.data, 32'h80000000);
            check("t5_lsb_first_index", px1.idx, 10'd0);
            send_word(1, 32'h12345678, 32);
            tick(3);
            px1 = get1(c_got + 1);
            check("t5_reversed_data", px1.data, 32'h1E6A2C48);
            check("t5_reversed_index", px1.idx, 10'd1);
            send_word(1, 32'h000003FF, 10);
            tick(IDLE);
            check("t5_partial_frame_end", fe1 - c_fe, 1);
            check("t5_partial_no_pixel", got1.size() - c_got, 2);
            check("t5_partial_no_error", err1 - c_err, 0);
         end
      join

      // Out-of-window pulse mid-pixel, then resync.
      b_got = got0.size(); b_err = err0; b_fe = fe0;
      send_word(0, 32'h00000015, 5);
      check("t3_busy_mid_pixel", d0_busy, 1'b1);
      drive(0, 1'b1); tick(60); drive(0, 1'b0); tick(85);
      check("t3_bit_error", err0 - b_err, 1);
      check("t3_busy_after_error", d0_busy, 1'b0);
      send_word(0, 32'h000002AB, 10);
      tick(IDLE);
      check("t3_sync_no_frame_end", fe0 - b_fe, 0);
      check("t3_garbage_no_pixel", got0.size() - b_got, 0);
      send_word(0, 32'h00C0FFEE, 24);
      tick(IDLE);
      px0 = get0(b_got);
      check("t3_count", got0.size() - b_got, 1);
      check("t3_data", px0.data, 32'h00C0FFEE);
      check("t3_index", px0.idx, 10'd0);
      check("t3_error_total", err0 - b_err, 1);
      check("t3_frame_end", fe0 - b_fe, 1);

      // Backpressure: second completion overruns, first word held.
      rdy0 = 1'b0;
      b_got = got0.size(); b_ov = ov0;
      send_word(0, 32'h00111111, 24);
      send_word(0, 32'h00222222, 24);
      check("t4_valid_held", d0_valid, 1'b1);
      check("t4_held_data", d0_data, 24'h111111);
      check("t4_held_index", d0_index, 10'd0);
      check("t4_overrun", ov0 - b_ov, 1);
      rdy0 = 1'b1;
      tick(2);
      check("t4_valid_dropped", d0_valid, 1'b0);
      px0 = get0(b_got);
      check("t4_transfer_count", got0.size() - b_got, 1);
      check("t4_transfer_data", px0.data, 32'h00111111);
      check("t4_hold_stable", hold_bad, 0);
      send_word(0, 32'h00333333, 24);
      tick(3);
      px0 = get0(b_got + 1);
      check("t4_next_data", px0.data, 32'h00333333);
      check("t4_next_index", px0.idx, 10'd2);

      // Asynchronous reset during bit 12 with a held word.
      rdy0 = 1'b0;
      send_word(0, 32'h00444444, 24);
      send_word(0, 32'h00000000, 11);
      drive(0, 1'b1);
      tick(20);
      check("t6_valid_before_reset", d0_valid, 1'b1);
      check("t6_data_before_reset", d0_data, 24'h444444);
      check("t6_index_before_reset", d0_index, 10'd3);
      #2 rst = 1'b1;
      #1;
      check("t6_async_reset",
            {d0_valid, d0_fe, d0_err, d0_ov, d0_busy, d0_index, d0_data}, '0);
      tick(3);
      rst  = 1'b0;
      rdy0 = 1'b1;
      b_got = got0.size(); b_err = err0; b_fe = fe0;
      tick(60); drive(0, 1'b0); tick(85);
      send_word(0, 32'h00000ABC, 12);
      tick(5);
      check("t6_no_pixel_before_sync", got0.size() - b_got, 0);
      check("t6_no_error_before_sync", err0 - b_err, 0);
      tick(IDLE);
      send_word(0, 32'h000F0F0F, 24);
      tick(3);
      px0 = get0(b_got);
      check("t6_count_after_sync", got0.size() - b_got, 1);
      check("t6_data_after_sync", px0.data, 32'h000F0F0F);
      check("t6_index_after_sync", px0.idx, 10'd0);
      check("t6_no_frame_end", fe0 - b_fe, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ws2812_pixel_decoder.md
Name: ws2812_pixel_decoder

Overview:
- Parametrised WS2812 receive front end that turns a synchronised serial data line directly into pixel words.
- Measures each high pulse and classifies it with configurable window comparators.
- Assembles BITS_PER_PIXEL bits per pixel (24 for RGB, 32 for RGBW) and detects the treset low period as the frame delimiter.
- Delivers pixels over a valid/ready handshake to the downstream shift/pixel pipeline. Reports bit errors and overruns.

Parameters:
CNT_WIDTH, 13, pulse/low counter width; must hold TRESET_CYCLES; counter saturates at all-ones
BITS_PER_PIXEL, 24, bits assembled per pixel word (24 RGB, 32 RGBW)
T0H_MIN, 25, minimum high cycles classified as 0
T0H_MAX, 55, maximum high cycles classified as 0
T1H_MIN, 65, minimum high cycles classified as 1
T1H_MAX, 100, maximum high cycles classified as 1
TRESET_CYCLES, 5000, low cycles that constitute a reset/latch
MSB_FIRST, 1, 1: first received bit lands in bit BITS_PER_PIXEL-1; 0: in bit 0
IDX_WIDTH, 10, width of the pixel index within a frame

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_din  input  1  WS2812 line, already synchronised to i_clk
o_pixel_data  output  BITS_PER_PIXEL  assembled pixel word
o_pixel_index  output  IDX_WIDTH  index of o_pixel_data within the current frame
o_pixel_valid  output  1  pixel word available
i_pixel_ready  input  1  downstream accepts the word
o_frame_end  output  1  one-cycle pulse on treset detection
o_bit_error  output  1  one-cycle pulse on out-of-window high pulse
o_overrun  output  1  one-cycle pulse when a completed pixel is dropped
o_busy  output  1  high in S_HIGH/S_LOW (frame in progress)

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-high on i_reset.
- Reset values: all outputs 0; state S_SYNC; counter 0; bit count 0; previous-din register 0; pixel index 0.
- Edge detection: from the registered previous i_din. A rise or fall is seen one cycle after i_din changes.
- Counter:
  - Cleared to 1 on any detected edge; increments each cycle otherwise.
  - Saturates at 2^CNT_WIDTH-1. On the fall cycle its value is the number of high samples.
- State machine:
  - S_SYNC: wait for line idle. Counter restarts on a rise. Counter reaching TRESET_CYCLES while low -> S_IDLE. No o_frame_end pulse.
  - S_IDLE: rise -> S_HIGH.
  - S_HIGH: on fall, classify the high count:
    - T1H window -> bit 1.
    - T0H window -> bit 0.
    - Neither -> o_bit_error pulse, discard partial pixel, bit count 0, go to S_SYNC.
    - The T1H window is checked first if the windows overlap.
    - Valid bit -> S_LOW.
  - S_LOW:
    - Rise -> S_HIGH.
    - Low count reaching TRESET_CYCLES -> one-cycle o_frame_end pulse, pixel index 0, go to S_IDLE.
    - A partial pixel (bit count != 0) is discarded silently at frame end.
- Bit assembly:
  - Shifts in at MSB_FIRST position.
  - After bit BITS_PER_PIXEL the word completes and bit count returns to 0.
- Output register: the word is loaded the cycle after the completing fall. o_pixel_valid rises that cycle, together with o_pixel_index.
  - Handshake: transfer occurs when o_pixel_valid && i_pixel_ready.
  - Data and index stay stable while valid && !ready.
  - Valid drops the cycle after transfer unless a new word loads that same cycle; in that case valid stays high with the new data.
  - Completion while valid && !ready: new word dropped, o_overrun pulses, held word unchanged.
  - Pixel index increments per word loaded (including overrun-dropped words), wraps at 2^IDX_WIDTH, clears at frame end.
  - A pending valid word is not affected by frame end or bit error.
- Reset mid-frame: immediate return to reset values. The in-flight pixel and the held word are lost.

Test Plan:
- Reset, hold i_din low 5000 cycles, send 24 bits 0xA5C3F0 (80 high/45 low for 1, 40 high/85 low for 0), ready=1 -> o_pixel_valid one cycle with data 0xA5C3F0, index 0, no errors.
- Three pixels back-to-back, then 5000 cycles low -> indexes 0,1,2; o_frame_end exactly one pulse; next frame restarts at index 0.
- High pulse of 60 cycles mid-pixel -> o_bit_error pulse, no pixel emitted. Bits before the next 5000-cycle low are ignored. The following frame decodes correctly.
- ready=0 while two pixels complete -> first word held stable, o_overrun pulse on the second; ready=1 later -> first word transferred, valid drops.
- MSB_FIRST=0, BITS_PER_PIXEL=32, send 0x00000001 MSB-first on the line -> o_pixel_data 0x80000000. Frame ending after 10 bits -> o_frame_end, no pixel, no error.
- Assert i_reset during bit 12 with a held valid word -> all outputs 0 asynchronously. After release, no pixel is emitted until a 5000-cycle low is seen.
